truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//  Sequencer stage that drives the 3-input combinational lab functions. Steps the
//  input vector {a,b,c} through all 2^N minterms and samples the function output
//  after a settle delay. Assembles the sampled bits into a truth-table word and
//  signals completion.
//  Sits directly upstream of the function block (drives a,b,c) and consumes its f output.
// PARAMETERS
//  NUM_VARS       3  number of function inputs; table width TW = 2**NUM_VARS
//  SETTLE_CYCLES  1  extra cycles each row is held before sampling (0 = sample in first cycle)
// PORTS
//  clk     in   1         single clock, rising edge
//  rst_n   in   1         asynchronous, active-low reset
//  start   in   1         request a scan; accepted only in IDLE
//  f_in    in   1         function output from the downstream combinational block
//  abc     out  NUM_VARS  input vector driven to the function block; {a,b,c} = abc[2:0]
//  table   out  TW        truth table; bit k = f_in sampled while abc==k
//  busy    out  1         high while a scan is in progress
//  done    out  1         one-cycle pulse when table is complete
//  ones    out  NUM_VARS+1  popcount of table (only with TT_ONES_COUNT_EN)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (any time, including mid-scan): abc=0, table=0, busy=0, done=0, ones=0; FSM=IDLE.
//  FSM states: IDLE, HOLD, DONE.
//   IDLE: start=1 -> HOLD next cycle; table<=0, abc<=0, hold counter<=SETTLE_CYCLES, busy<=1.
//   HOLD: while counter!=0, decrement. At counter==0 (sample cycle):
//     table[abc] <= f_in.
//     If abc==TW-1 -> DONE. Otherwise abc<=abc+1 and counter<=SETTLE_CYCLES.
//   DONE: done=1 for exactly this cycle; busy=0; abc<=0. Next state is IDLE.
//  Timing: each row is held SETTLE_CYCLES+1 cycles and sampled on its last cycle.
//   The start-accept edge to the done cycle spans TW*(SETTLE_CYCLES+1)+1 cycles
//   (N=3, S=1: 17).
//  start is ignored in HOLD and DONE. No queuing: start must be re-asserted in IDLE.
//  table holds its value after done until the next accepted start clears it.
//  busy is registered. busy=1 from the cycle after start is accepted through the last sample cycle.
//  abc wraps never: the scan stops at TW-1. abc width arithmetic is unsigned and NUM_VARS bits wide.
//  f_in is sampled synchronously. The function block must settle within SETTLE_CYCLES+1 cycles.
// CONFIGURATION
//  TT_ONES_COUNT_EN defined:
//   - ones port exists.
//   - ones is a register updated with table; it equals popcount(table).
//   - ones clears on start.
//   - ones is valid when done=1.
//  TT_ONES_COUNT_EN undefined:
//   - ones port and its logic are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  Shared package tt_pkg:
//   - state typedef (IDLE/HOLD/DONE)
//   - localparam computing TW from NUM_VARS
//  Single module, no sub-modules. The settle counter is inline, with width $clog2(SETTLE_CYCLES+1), minimum 1.
//  Bench instantiates the scanner driving the existing 3-input function block.
// TESTING
//  1. Reset, then start with golden f = ~b&~c | ~a&b | a&c (N=3, S=1):
//     done at +17 cycles, table=8'hBD, ones=6.
//  2. f_in tied 0, then tied 1, with S=0:
//     table=8'h00 and then 8'hFF; done at +9 cycles each.
//  3. start pulsed again mid-scan:
//     ignored; a single done; table unaffected. start re-asserted the cycle after done is accepted.
//  4. rst_n dropped asynchronously mid-scan (abc=5):
//     all outputs 0 immediately. A fresh start then yields a correct table.
//  5. abc trace check: abc walks 0..7, each value held S+1 cycles, then returns to 0 in the DONE cycle.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and width helpers for the truth-table scanner.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // Truth-table width for an n-input function.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Settle counter width; a zero settle still needs a one-bit counter.
  function automatic int unsigned tt_cnt_width(input int unsigned s);
    return (s == 32'd0) ? 32'd1 : $clog2(s + 32'd1);
  endfunction

  localparam int unsigned TT_NUM_VARS = 32'd3;
  localparam int unsigned TT_TW       = tt_width(TT_NUM_VARS);

endpackage

// File: rtl/truth_table_scanner.sv
// Steps {a,b,c} through every minterm, samples f_in after a settle hold and builds the table.
// Define TT_ONES_COUNT_EN to add the registered popcount output 'ones'.
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int unsigned NUM_VARS      = TT_NUM_VARS,
  parameter int unsigned SETTLE_CYCLES = 32'd1,
  localparam int unsigned TW           = tt_width(NUM_VARS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                f_in,
  output logic [NUM_VARS-1:0] abc,
  output logic [TW-1:0]       table_o,
  output logic                busy,
  output logic                done
`ifdef TT_ONES_COUNT_EN
  ,
  output logic [NUM_VARS:0]   ones
`endif
);

  localparam int unsigned CW = tt_cnt_width(SETTLE_CYCLES);

  localparam logic [CW-1:0]       CNT_RELOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]       CNT_ONE    = CW'(32'd1);
  localparam logic [NUM_VARS-1:0] ABC_ONE    = NUM_VARS'(32'd1);
  localparam logic [NUM_VARS-1:0] ABC_LAST   = NUM_VARS'(TW - 32'd1);

  tt_state_e           state_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_VARS-1:0] abc_q;
  logic [TW-1:0]       table_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_VARS:0]   ones_q;

  // Scan sequencer: state, row pointer, settle counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abc_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= HOLD;
            table_q <= '0;
            ones_q  <= '0;
            abc_q   <= '0;
            cnt_q   <= CNT_RELOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            // Each bit is written once per scan, so a running sum equals the popcount.
            table_q[abc_q] <= f_in;
            ones_q         <= ones_q + (NUM_VARS + 1)'(f_in);
            if (abc_q == ABC_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              abc_q   <= '0;
            end else begin
              abc_q <= abc_q + ABC_ONE;
              cnt_q <= CNT_RELOAD;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          abc_q   <= '0;
        end
      endcase
    end
  end

  assign abc     = abc_q;
  assign table_o = table_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef TT_ONES_COUNT_EN
  assign ones = ones_q;
`else
  logic unused_ones_s;
  assign unused_ones_s = ^ones_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized bench: two scanners (settle 0 and 1) each driving a table-defined 3-input function.
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [7:0] ftab [2];

  logic [2:0] abc0, abc1;
  logic [7:0] tab0, tab1;
  logic       busy0, busy1, done0, done1;
  logic       f0, f1;
`ifdef TT_ONES_COUNT_EN
  logic [3:0] ones0, ones1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign f0 = ftab[0][abc0];
  assign f1 = ftab[1][abc1];

  truth_table_scanner #(.NUM_VARS(3), .SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .f_in(f0),
    .abc(abc0), .table_o(tab0), .busy(busy0), .done(done0)
`ifdef TT_ONES_COUNT_EN
    , .ones(ones0)
`endif
  );

  truth_table_scanner #(.NUM_VARS(3), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .f_in(f1),
    .abc(abc1), .table_o(tab1), .busy(busy1), .done(done1)
`ifdef TT_ONES_COUNT_EN
    , .ones(ones1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int popcnt(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  // Golden lab function f = ~b&~c | ~a&b | a&c evaluated per minterm.
  function automatic logic [7:0] golden_tab();
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      bit a, b, c;
      a = (k / 4) % 2 == 1;
      b = (k / 2) % 2 == 1;
      c = k % 2 == 1;
      t[k] = (!b && !c) || (!a && b) || (a && c);
    end
    return t;
  endfunction

  task automatic check_idle_zero(input int idx, input string tag);
    check_eq({tag, "_abc"},   idx == 1 ? abc1  : abc0,  32'd0);
    check_eq({tag, "_table"}, idx == 1 ? tab1  : tab0,  32'd0);
    check_eq({tag, "_busy"},  idx == 1 ? busy1 : busy0, 32'd0);
    check_eq({tag, "_done"},  idx == 1 ? done1 : done0, 32'd0);
`ifdef TT_ONES_COUNT_EN
    check_eq({tag, "_ones"},  idx == 1 ? ones1 : ones0, 32'd0);
`endif
  endtask

  // One scan on instance idx; the reference derives every cycle's outputs from its index
  // after the accept edge. With 'noisy', start is pulsed mid-scan and again during done.
  task automatic scan(input int idx, input logic [7:0] ft, input bit noisy, input int stop_at);
    int s, lat, ndone, rows;
    logic [7:0] part;
    s   = idx;
    lat = 8 * (s + 1) + 1;
    ndone = 0;
    ftab[idx] = ft;
    @(negedge clk);
    start[idx] = 1'b1;
    for (int n = 1; n <= lat + 2; n++) begin
      @(negedge clk);
      start[idx] = noisy && (n == 4 || n == lat);
      rows = (n <= lat) ? (n - 1) / (s + 1) : 8;
      part = 8'(ft & 8'((32'd1 << rows) - 32'd1));
      if (n > lat) part = ft;
      if ((idx == 1 ? done1 : done0) === 1'b1) ndone++;
      check_eq($sformatf("s%0d_n%0d_abc", s, n), idx == 1 ? abc1 : abc0,
               (n < lat) ? 32'((n - 1) / (s + 1)) : 32'd0);
      check_eq($sformatf("s%0d_n%0d_busy", s, n), idx == 1 ? busy1 : busy0, 32'(n < lat));
      check_eq($sformatf("s%0d_n%0d_done", s, n), idx == 1 ? done1 : done0, 32'(n == lat));
      check_eq($sformatf("s%0d_n%0d_table", s, n), idx == 1 ? tab1 : tab0, 32'(part));
`ifdef TT_ONES_COUNT_EN
      check_eq($sformatf("s%0d_n%0d_ones", s, n), idx == 1 ? ones1 : ones0, 32'(popcnt(part)));
`endif
      if (n == stop_at) return;
    end
    start[idx] = 1'b0;
    check_eq($sformatf("s%0d_done_count", s), 32'(ndone), 32'd1);
  endtask

  initial begin
    logic [7:0] r;
    start   = 2'b00;
    ftab[0] = 8'h00;
    ftab[1] = 8'h00;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero(0, "rst0");
    check_idle_zero(1, "rst1");
    rst_n = 1'b1;

    // Golden function, settle 1: table BD after 17 cycles.
    scan(1, golden_tab(), 1'b0, 0);
    check_eq("golden_table", tab1, 32'h0000_00BD);
`ifdef TT_ONES_COUNT_EN
    check_eq("golden_ones", ones1, 32'd6);
`endif

    // Constant functions, settle 0.
    scan(0, 8'h00, 1'b0, 0);
    scan(0, 8'hFF, 1'b0, 0);

    // Start pulses in HOLD and DONE must be ignored.
    scan(1, golden_tab(), 1'b1, 0);
    scan(0, 8'(($urandom)), 1'b1, 0);

    // Table holds after done while idle.
    repeat (4) @(negedge clk);
    check_eq("hold_table", tab1, 32'h0000_00BD);

    // Asynchronous reset mid-scan while abc == 5.
    r = 8'($urandom);
    scan(1, r, 1'b0, 11);
    check_eq("pre_rst_abc", abc1, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero(1, "async1");
    check_idle_zero(0, "async0");
    @(negedge clk);
    rst_n = 1'b1;
    scan(1, 8'($urandom), 1'b0, 0);

    // Random functions on both instances.
    for (int i = 0; i < 6; i++) begin
      scan(i % 2, 8'($urandom), ($urandom_range(0, 1) == 1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "bench timeout");
  end

endmodule
